// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller. Synchronizes the serial line, qualifies start bits,
// samples bits on the baud strobe and hands bytes over through a one-entry holding register.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  input  logic       i_rx_strb,
  input  logic       i_parity_odd,
  input  logic       i_ready,
  output logic       o_rx_strb_en,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_overrun,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_strb_en;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   w_par_err;

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic r_parity_err;
  assign w_par_err    = r_par_err;
  assign o_parity_err = r_parity_err;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = i_parity_odd;
  assign w_par_err           = 1'b0;
  assign o_parity_err        = 1'b0;
`endif

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_strb_en   <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in this
      // block, so pulses fall back to 0 and the handshake clear loses to a new load.
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (r_valid && i_ready) r_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state   <= ST_START;
            r_strb_en <= 1'b1;
          end
        end

        ST_START: begin
          if (i_rx_strb) begin
            if (w_rx_s) begin
              r_state   <= ST_IDLE;
              r_strb_en <= 1'b0;
            end else begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
        end

        ST_DATA: begin
          if (i_rx_strb) begin
            r_shift[r_bit_cnt] <= w_rx_s;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (i_rx_strb) begin
            r_par_err <= ((^r_shift) ^ w_rx_s) != i_parity_odd;
            r_state   <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (i_rx_strb) begin
            r_strb_en <= 1'b0;
            if (!w_rx_s) begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HIGH;
            end else if (w_par_err) begin
`ifdef UART_RX_PARITY_EN
              r_parity_err <= 1'b1;
`endif
              r_state <= ST_IDLE;
            end else begin
              // A read on this same edge frees the holding register for the new byte.
              if (!r_valid || i_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              r_state <= ST_IDLE;
            end
          end
        end

        ST_WAIT_HIGH: begin
          if (w_rx_s) r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rx_strb_en = r_strb_en;
  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl with a behavioural baud generator,
// a frame-level line driver and a queue-based model of delivered bytes.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAST_STRB = PAR_EN ? 11 : 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_rx_strb = 1'b0;
  logic       i_parity_odd = 1'b0;
  logic       i_ready = 1'b0;
  logic       o_rx_strb_en;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_overrun;
  logic       o_busy;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (i_rx),
    .i_rx_strb   (i_rx_strb),
    .i_parity_odd(i_parity_odd),
    .i_ready     (i_ready),
    .o_rx_strb_en(o_rx_strb_en),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_parity_err(o_parity_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // Baud generator model: first strobe half a bit after enable, then one per bit.
  int bit_cycles = 32;
  int bcnt = 0;
  int sidx = 0;
  bit ready_on_stop = 1'b0;
  bit ready_pulse = 1'b0;
  bit stray = 1'b0;

  always @(negedge clk) begin
    if (ready_pulse) begin
      i_ready     = 1'b0;
      ready_pulse = 1'b0;
    end
    if (!o_rx_strb_en) begin
      bcnt      = 0;
      sidx      = 0;
      i_rx_strb = stray;
    end else begin
      bcnt++;
      i_rx_strb = (bcnt >= bit_cycles / 2) && ((bcnt - bit_cycles / 2) % bit_cycles == 0);
      if (i_rx_strb) begin
        sidx++;
        if (sidx == LAST_STRB && ready_on_stop) begin
          i_ready     = 1'b1;
          ready_pulse = 1'b1;
        end
      end
    end
  end

  // Output monitor.
  int         n_ferr, n_perr, n_ovr, n_vrise, n_vcyc, n_en_with_valid;
  bit         en_seen;
  logic       prev_valid = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (o_frame_err)  n_ferr++;
    if (o_parity_err) n_perr++;
    if (o_overrun)    n_ovr++;
    if (o_valid)      n_vcyc++;
    if (o_rx_strb_en) en_seen = 1'b1;
    if (o_valid && !prev_valid) begin
      n_vrise++;
      got_q.push_back(o_data);
      if (o_rx_strb_en) n_en_with_valid++;
    end
    prev_valid = o_valid;
  end

  task automatic clear_counts();
    n_ferr = 0; n_perr = 0; n_ovr = 0; n_vrise = 0; n_vcyc = 0;
    n_en_with_valid = 0; en_seen = 1'b0;
    got_q.delete();
  endtask

  function automatic logic good_par(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  task automatic send_bit(input logic v);
    i_rx = v;
    repeat (bit_cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_rx_strb_en, o_data, o_valid, o_frame_err, o_parity_err, o_overrun, o_busy} !== 14'h0)
      $display("FAIL reset_held: got en=%b data=%h valid=%b busy=%b, expected all 0",
               o_rx_strb_en, o_data, o_valid, o_busy);
    else n_pass++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({o_rx_strb_en, o_data, o_valid, o_frame_err, o_parity_err, o_overrun, o_busy} !== 14'h0)
      $display("FAIL reset_idle: got en=%b data=%h valid=%b busy=%b, expected all 0",
               o_rx_strb_en, o_data, o_valid, o_busy);
    else n_pass++;
  endtask

  task automatic test_start_latency();
    int k;
    bit_cycles = 32;
    i_ready = 1'b1;
    clear_counts();
    k = 0;
    fork
      send_frame(8'h3B, good_par(8'h3B, i_parity_odd), 1'b1);
      begin
        for (int c = 1; c <= 20; c++) begin
          @(posedge clk); #1;
          if (o_rx_strb_en) begin k = c; break; end
        end
      end
    join
    repeat (4) @(negedge clk);
    n_checks++;
    if (k !== SYNC + 1) $display("FAIL start_latency: got %0d edges, expected %0d", k, SYNC + 1);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h3B)
      $display("FAIL latency_frame: got %0d bytes first=%h, expected 1 byte 3b",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00);
    else n_pass++;
  endtask

  task automatic test_basic();
    bit_cycles = 868;
    i_ready = 1'b1;
    clear_counts();
    send_frame(8'hA5, good_par(8'hA5, i_parity_odd), 1'b1);
    repeat (10) @(negedge clk);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5)
      $display("FAIL basic_data: got %0d bytes first=%h, expected 1 byte a5",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00);
    else n_pass++;
    n_checks++;
    if (n_vcyc !== 1) $display("FAIL basic_valid_width: got %0d cycles, expected 1", n_vcyc);
    else n_pass++;
    n_checks++;
    if (n_ferr + n_perr + n_ovr !== 0)
      $display("FAIL basic_no_err: got %0d pulses, expected 0", n_ferr + n_perr + n_ovr);
    else n_pass++;
    n_checks++;
    if (n_en_with_valid !== 0 || o_rx_strb_en !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL basic_en_drop: got en_with_valid=%0d en=%b busy=%b, expected 0 0 0",
               n_en_with_valid, o_rx_strb_en, o_busy);
    else n_pass++;
  endtask

  task automatic test_false_start();
    bit_cycles = 868;
    clear_counts();
    i_rx = 1'b0;
    repeat (200) @(negedge clk);
    i_rx = 1'b1;
    repeat (900) @(negedge clk);
    n_checks++;
    if (en_seen !== 1'b1 || o_rx_strb_en !== 1'b0)
      $display("FAIL false_start_en: got seen=%b now=%b, expected 1 0", en_seen, o_rx_strb_en);
    else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0 || n_vrise !== 0 || n_ferr !== 0)
      $display("FAIL false_start_idle: got busy=%b valid_events=%0d ferr=%0d, expected 0 0 0",
               o_busy, n_vrise, n_ferr);
    else n_pass++;
  endtask

  task automatic test_stray_strobe();
    clear_counts();
    stray = 1'b1;
    repeat (6) @(negedge clk);
    stray = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || n_vrise !== 0 || n_ferr !== 0)
      $display("FAIL stray_strobe: got busy=%b valid_events=%0d ferr=%0d, expected 0 0 0",
               o_busy, n_vrise, n_ferr);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    bit_cycles = 32;
    i_ready = 1'b1;
    clear_counts();
    send_frame(8'h3C, good_par(8'h3C, i_parity_odd), 1'b0);
    repeat (3 * bit_cycles) @(negedge clk);
    n_checks++;
    if (n_ferr !== 1 || n_vrise !== 0)
      $display("FAIL frame_err_pulse: got ferr=%0d valid_events=%0d, expected 1 0", n_ferr, n_vrise);
    else n_pass++;
    n_checks++;
    if (o_busy !== 1'b1 || o_rx_strb_en !== 1'b0)
      $display("FAIL frame_err_wait: got busy=%b en=%b, expected 1 0", o_busy, o_rx_strb_en);
    else n_pass++;
    send_bit(1'b1);
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL frame_err_release: got busy=%b, expected 0", o_busy);
    else n_pass++;
    send_frame(8'h11, good_par(8'h11, i_parity_odd), 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h11 || n_ferr !== 1)
      $display("FAIL frame_err_recover: got %0d bytes first=%h ferr=%0d, expected 1 byte 11 ferr 1",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, n_ferr);
    else n_pass++;
  endtask

  task automatic test_overrun();
    bit_cycles = 32;
    i_ready = 1'b0;
    clear_counts();
    send_frame(8'h01, good_par(8'h01, i_parity_odd), 1'b1);
    send_frame(8'h02, good_par(8'h02, i_parity_odd), 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (o_data !== 8'h01 || o_valid !== 1'b1)
      $display("FAIL overrun_hold: got data=%h valid=%b, expected 01 1", o_data, o_valid);
    else n_pass++;
    n_checks++;
    if (n_ovr !== 1) $display("FAIL overrun_pulse: got %0d pulses, expected 1", n_ovr);
    else n_pass++;
    ready_on_stop = 1'b1;
    send_frame(8'h02, good_par(8'h02, i_parity_odd), 1'b1);
    ready_on_stop = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_data !== 8'h02 || o_valid !== 1'b1 || n_ovr !== 1)
      $display("FAIL overrun_read_same_edge: got data=%h valid=%b ovr=%0d, expected 02 1 1",
               o_data, o_valid, n_ovr);
    else n_pass++;
    i_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0) $display("FAIL handshake_clear: got valid=%b, expected 0", o_valid);
    else n_pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    bit_cycles = 32;
    i_ready = 1'b1;
    i_parity_odd = 1'b1;
    clear_counts();
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h07 || n_perr !== 0)
      $display("FAIL parity_good: got %0d bytes perr=%0d, expected 1 byte 07 perr 0",
               got_q.size(), n_perr);
    else n_pass++;
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_perr !== 1 || n_vrise !== 0 || o_valid !== 1'b0)
      $display("FAIL parity_bad: got perr=%0d valid_events=%0d valid=%b, expected 1 0 0",
               n_perr, n_vrise, o_valid);
    else n_pass++;
    i_parity_odd = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] d;
    bit_cycles = 32;
    i_ready = 1'b1;
    d = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    i_rx = d[4];
    repeat (bit_cycles / 2) @(negedge clk);
    clear_counts();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_rx_strb_en, o_data, o_valid, o_frame_err, o_parity_err, o_overrun, o_busy} !== 14'h0)
      $display("FAIL reset_mid_outputs: got en=%b data=%h valid=%b busy=%b, expected all 0",
               o_rx_strb_en, o_data, o_valid, o_busy);
    else n_pass++;
    i_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (bit_cycles) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || n_vrise + n_ferr + n_perr + n_ovr !== 0)
      $display("FAIL reset_mid_quiet: got busy=%b events=%0d, expected 0 0",
               o_busy, n_vrise + n_ferr + n_perr + n_ovr);
    else n_pass++;
    send_frame(8'h5A, good_par(8'h5A, i_parity_odd), 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A)
      $display("FAIL reset_mid_next: got %0d bytes first=%h, expected 1 byte 5a",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       odd, bad;
    int         n_bad;
    bit_cycles = 32;
    i_ready = 1'b1;
    clear_counts();
    n_bad = 0;
    for (int f = 0; f < 12; f++) begin
      d   = 8'($urandom);
      odd = PAR_EN ? 1'($urandom) : 1'b0;
      bad = PAR_EN && ($urandom_range(0, 3) == 0);
      i_parity_odd = odd;
      if (bad) n_bad++;
      else exp_q.push_back(d);
      send_frame(d, good_par(d, odd) ^ bad, 1'b1);
      repeat ($urandom_range(0, 2) * bit_cycles) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL b2b_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (n_perr !== n_bad || n_ferr !== 0 || n_ovr !== 0)
      $display("FAIL b2b_errors: got perr=%0d ferr=%0d ovr=%0d, expected %0d 0 0",
               n_perr, n_ferr, n_ovr, n_bad);
    else n_pass++;
    i_parity_odd = 1'b0;
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_start_latency();
    test_basic();
    test_false_start();
    test_stray_strobe();
    test_frame_err();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART baud generator. It watches the serial input, detects and qualifies start bits, gates the baud generator's RX strobe enable, and samples each bit on the mid-bit strobe. Completed bytes go to the register layer through a one-entry holding register with a valid/ready handshake, together with error pulses.

## Interface
- SYNC_STAGES, 2: flops in the `i_rx` metastability synchronizer, minimum 2.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_rx  in  1  asynchronous serial line; idle high.
- i_rx_strb  in  1  mid-bit strobe from the baud generator, single cycle.
- i_parity_odd  in  1  1 = odd parity, 0 = even. Used only when parity is compiled in.
- i_ready  in  1  consumer accepts the held byte.
- o_rx_strb_en  out  1  enable to the baud generator RX strobe.
- o_data  out  8  received byte, LSB first on the line.
- o_valid  out  1  `o_data` is held and unread.
- o_frame_err  out  1  1-cycle pulse: stop bit sampled low.
- o_parity_err  out  1  1-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.
- o_overrun  out  1  1-cycle pulse: a byte was dropped because the holding register was full.
- o_busy  out  1  FSM not in IDLE.

## Operation
- `rx_s` is `i_rx` after SYNC_STAGES flops. All line decisions use `rx_s` only.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE:** `rx_s`==0 moves to START. `o_rx_strb_en` goes to 1 on that edge.
- **START:** waits for `i_rx_strb`.
  - `rx_s`==1 at the strobe is a false start: go to IDLE and drop the enable.
  - Otherwise go to DATA with the bit counter at 0.
- **DATA:** each strobe shifts `rx_s` into bit[counter], LSB first.
  - After bit 7: go to PARITY if compiled in, otherwise STOP.
- **PARITY:** one strobe samples the parity bit. The mismatch flag is held until STOP.
- **STOP:** one strobe samples the stop bit; the enable drops on the same edge.
  - Stop bit = 0: byte discarded, `o_frame_err` pulses, go to WAIT_HIGH.
  - Parity mismatch with stop bit = 1: byte discarded, `o_parity_err` pulses, go to IDLE.
  - Otherwise the byte is delivered (see below) and the FSM goes to IDLE.
- **WAIT_HIGH:** remain until `rx_s`==1, then go to IDLE. A break line never produces repeated frames.
- **Delivery:**
  - `o_valid`==0: load `o_data` and set `o_valid`.
  - `o_valid`==1 and `i_ready`==1 on the same edge: load the new byte and keep `o_valid` at 1. No overrun.
  - `o_valid`==1 and `i_ready`==0: the new byte is dropped, the old byte is kept and `o_overrun` pulses.
- **Handshake:** `o_valid` && `i_ready` clears `o_valid` unless a new byte loads on the same edge. `o_data` is stable while `o_valid`==1.
- **Parity:**
  - Even: XOR of the 8 data bits and the parity bit must be 0.
  - Odd: the same XOR must be 1.
  - `i_parity_odd` is sampled when parity is checked. Software changes it only while `o_busy`==0.

## Timing
- Reset values: FSM IDLE, synchronizer flops 1. All outputs 0 (`o_data`=0x00).
- Start edge to `o_rx_strb_en`=1: SYNC_STAGES+1 clk edges.
- The baud generator fires its first strobe half a bit after the enable, i.e. mid start bit, then one strobe per bit.
- Stop-bit strobe to `o_valid`/error pulse: registered, visible 1 cycle after the strobe cycle.
- `o_rx_strb_en` is 0 in the cycle after the stop strobe. The generator counter reloads, so the next frame's timing is independent of this one.
- `i_rx_strb` while the FSM is in IDLE or WAIT_HIGH is ignored.
- Reset mid-frame: immediate return to IDLE with enable 0; the partial byte is lost and no pulses are produced.
- Total frame occupancy: 10 bit periods, or 11 with parity, plus synchronizer latency.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state and parity checking are compiled in. The frame is start + 8 data + parity + stop.
- Undefined: the PARITY state does not exist, `o_parity_err` is constant 0, `i_parity_odd` is unused, and the frame is start + 8 data + stop.

## Test plan
- **Basic byte:** CLK_FREQ 100 MHz, 115200 baud (divider 868), frame 0xA5, `i_ready`=1 -> `o_data`=0xA5 and `o_valid` high exactly 1 cycle. No error pulses. `o_rx_strb_en` low after the stop strobe.
- **False start:** 200-cycle low glitch on `i_rx` -> FSM back to IDLE after the first strobe. `o_valid` stays 0; `o_rx_strb_en` pulses and drops.
- **Framing error:** frame 0x3C with stop bit 0, then line held low for 3 bit times -> one `o_frame_err` pulse and no `o_valid`. Only after the line rises does a frame 0x11 give `o_data`=0x11.
- **Overrun:** 0x01 then 0x02 back-to-back with `i_ready`=0 -> `o_data` stays 0x01 and `o_overrun` pulses once. With `i_ready`=1 exactly on the 0x02 load edge: `o_data`=0x02 and no overrun.
- **Parity (macro defined):** odd parity, frame 0x07 with parity bit 0 -> byte delivered. Same frame with parity bit 1 -> `o_parity_err` pulse, `o_valid` stays 0.
- **Reset mid-frame:** `rst_n` low at data bit 4 -> all outputs 0 and FSM in IDLE. Next frame 0x5A is received correctly.
